irq_gen: RTL and testbench
==========================

Name: irq_gen

Overview:
- Interrupt request generator. It is the source end of the CPU interrupt-request interface; the CPU control unit masks and detects the lines it drives.
- Collects raw event lines from peripherals, synchronises them, and latches them as pending per channel in edge or level mode.
- Drives the registered IRQ bus into the CPU.
- A bus-slave register port gives software enable, mode, software-set and write-1-to-clear acknowledge access.

Parameters:
- CH, 8, number of interrupt channels. Must equal the CPU IRQ channel count; 1..32.
- DATA_W, 32, bus data width.

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous reset, active-low
- cs_  in  1  chip select, active-low
- as_  in  1  address strobe, active-low; a request is cs_=0 and as_=0 in one cycle
- rw  in  1  1 = read, 0 = write
- addr  in  2  word register index
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data, valid while rdy_=0
- rdy_  out  1  ready, active-low
- src  in  CH  raw peripheral event lines, asynchronous to clk
- irq  out  CH  interrupt requests to the CPU, registered

Behaviour:
- Reset (reset_=0, asynchronous): sync stages, prev, PEND, EDGE, EN and irq = 0; rd_data = 0; rdy_ = 1.
- Synchroniser: s1 <= src, s2 <= s1, prev <= s2 on every edge.
- Edge-mode event: s2 & ~prev.
- Register map (reads zero-extend CH bits to DATA_W):
  - 0 PEND: read pending; write 1 clears bit, 0 has no effect.
  - 1 EDGE: R/W; bit=1 rising-edge latched, bit=0 level.
  - 2 EN: R/W forwarding enable.
  - 3 RAW: read returns s2; write 1 sets pending (software interrupt), 0 has no effect.
- Channel in edge mode:
  - PEND_next = (PEND & ~clr) | edge_evt | swset.
  - Set wins over clear in the same cycle; no event is lost.
- Channel in level mode:
  - PEND_next = s2 | swset | (PEND & ~clr).
  - Clearing while s2=1 has no effect; the bit re-asserts.
- irq <= PEND & EN, registered. Clearing EN drops irq the next cycle; PEND is kept.
- Latency: src rises before edge k -> s1 after k, s2 after k+1, PEND after k+2, irq after k+3.
- Pulse width: a src pulse shorter than one clk period is not guaranteed to be captured.
- Bus handshake:
  - A request in cycle n: writes take effect at edge n; rdy_=0 and rd_data valid for exactly cycle n+1.
  - Otherwise rdy_=1 and rd_data=0.
  - Back-to-back requests are accepted every cycle.
  - A read samples register state before same-cycle updates.
- Mode change: writing EDGE does not modify PEND. A level channel switched to edge mode keeps its pending bit until cleared.
- Reset mid-transaction: everything returns to reset values immediately; the pending rdy_ is dropped.
- Unused upper wr_data bits are ignored.

Test Plan:
- Reset values: assert reset_=0 mid-operation with PEND=8'hFF -> irq=0, rdy_=1, rd_data=0 immediately. After release, reads of regs 0-2 return 0.
- Edge latency: EN=8'h01, EDGE=8'h01; raise src[0] before edge k -> PEND[0]=1 after k+2, irq[0]=1 after k+3. Holding src high produces no second event.
- Acknowledge versus new event: edge channel 0 pending; write PEND=0x1 in the same cycle as a new edge_evt on ch0 -> PEND[0] stays 1. A clear with no event -> irq[0]=0 one cycle later.
- Level mode: EDGE=0, EN=8'h80, src[7] held high -> irq[7]=1. A write-1-clear while high -> PEND[7] stays 1. Drop src[7] then clear -> irq[7]=0.
- Software set and mask: write RAW=0x0C with EN=0x04 -> PEND=0x0C, irq=0x04. Write EN=0 -> irq=0 next cycle, PEND still reads 0x0C.
- Bus timing: back-to-back write EN=0x5A then read EN -> rdy_ low in both following cycles; the read returns 32'h0000005A. A request with cs_=1 -> rdy_ stays 1.

Source files
------------

// File: rtl/irq_gen.sv
// irq_gen: interrupt request generator; synchronised, edge/level-latched pending bits with a bus-slave register port
module irq_gen #(
   parameter int CH = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              cs_,
   input  logic              as_,
   input  logic              rw,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rdy_,
   input  logic [CH-1:0]     src,
   output logic [CH-1:0]     irq
);
   logic [CH-1:0] s1, s2, prev, pend, edge_m, en, wd, clr, swset, pend_nx;
   logic [DATA_W-1:0] rd_mux;
   logic req, wr, unused_wr_data;
   always_comb begin
      req = ~cs_ & ~as_;
      wr = req & ~rw;
      wd = wr_data[CH-1:0];
      unused_wr_data = ^wr_data;
      clr = (wr && addr == 2'd0) ? wd : '0;
      swset = (wr && addr == 2'd3) ? wd : '0;
      // a fresh event or software set always beats a same-cycle acknowledge
      pend_nx = (pend & ~clr) | swset | (edge_m & s2 & ~prev) | (~edge_m & s2);
      rd_mux = addr == 2'd0 ? DATA_W'(pend) :
               addr == 2'd1 ? DATA_W'(edge_m) :
               addr == 2'd2 ? DATA_W'(en) : DATA_W'(s2);
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
         pend <= '0;
         edge_m <= '0;
         en <= '0;
         irq <= '0;
         rd_data <= '0;
         rdy_ <= 1'b1;
      end else begin
         s1 <= src;
         s2 <= s1;
         prev <= s2;
         pend <= pend_nx;
         if (wr && addr == 2'd1) edge_m <= wd;
         if (wr && addr == 2'd2) en <= wd;
         irq <= pend & en;
         rdy_ <= ~req;
         rd_data <= (req && rw) ? rd_mux : '0;
      end
   end
endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen: directed bench with a bus-response scoreboard for irq_gen
module tb_irq_gen;
   logic clk, reset_, cs_, as_, rw;
   logic [1:0] addr;
   logic [31:0] wr_data, rd_data;
   logic rdy_;
   logic [7:0] src, irq;
   int nvec = 0, nerr = 0, cyc = 0;
   typedef struct {
      logic rd;
      int due;
      logic [31:0] d;
      string tag;
   } exp_t;
   exp_t q[$];

   irq_gen dut (.clk(clk), .reset_(reset_), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
                .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .src(src), .irq(irq));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // one clock; at the following negedge, retire any bus response due now
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk({e.tag, "_rdy"}, {31'd0, rdy_}, 32'd0);
         if (e.rd) chk(e.tag, rd_data, e.d);
      end else chk("rdy_idle", {31'd0, rdy_}, 32'd1);
      cs_ = 1'b1;
      as_ = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      exp_t e;
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
      e.rd = 1'b0; e.due = cyc + 1; e.d = '0; e.tag = "wr";
      q.push_back(e);
      tick();
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] d, input string tag);
      exp_t e;
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a; wr_data = '0;
      e.rd = 1'b1; e.due = cyc + 1; e.d = d; e.tag = tag;
      q.push_back(e);
      tick();
   endtask

   initial begin
      reset_ = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0; src = '0;
      #12;
      chk("rst_irq", {24'd0, irq}, 32'd0);
      chk("rst_rdy", {31'd0, rdy_}, 32'd1);
      chk("rst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;
      idle(2);
      // edge latency on channel 0
      wr(2'd2, 32'h01);
      wr(2'd1, 32'h01);
      src[0] = 1'b1;
      idle(2);
      chk("lat_irq_k1", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h0, "lat_pend_k2");
      chk("lat_irq_k2", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h1, "lat_pend_k3");
      chk("lat_irq_k3", {24'd0, irq}, 32'h01);
      idle(3);
      wr(2'd0, 32'h1);
      chk("clr_irq_same", {24'd0, irq}, 32'h01);
      tick();
      chk("clr_irq_next", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h0, "hold_no_event");
      // acknowledge colliding with a new edge
      src[0] = 1'b0;
      idle(3);
      src[0] = 1'b1;
      idle(3);
      src[0] = 1'b0;
      idle(3);
      src[0] = 1'b1;
      idle(2);
      wr(2'd0, 32'h1);
      rd(2'd0, 32'h1, "ack_vs_evt_pend");
      chk("ack_vs_evt_irq", {24'd0, irq}, 32'h01);
      wr(2'd0, 32'h1);
      tick();
      chk("ack_irq_drop", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h0, "ack_pend_clr");
      // level mode on channel 7
      src[0] = 1'b0;
      idle(3);
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h80);
      wr(2'd0, 32'hFF);
      src[7] = 1'b1;
      idle(4);
      chk("lvl_irq", {24'd0, irq}, 32'h80);
      wr(2'd0, 32'h80);
      rd(2'd0, 32'h80, "lvl_clr_while_high");
      chk("lvl_irq_held", {24'd0, irq}, 32'h80);
      src[7] = 1'b0;
      idle(3);
      wr(2'd0, 32'h80);
      tick();
      chk("lvl_irq_drop", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h0, "lvl_pend_clr");
      // software set and masking
      wr(2'd2, 32'h04);
      wr(2'd3, 32'h0C);
      chk("sw_irq_early", {24'd0, irq}, 32'd0);
      tick();
      chk("sw_irq", {24'd0, irq}, 32'h04);
      rd(2'd0, 32'h0C, "sw_pend");
      wr(2'd2, 32'h0);
      tick();
      chk("mask_irq", {24'd0, irq}, 32'd0);
      rd(2'd0, 32'h0C, "mask_pend_kept");
      // bus timing, upper write bits ignored, deselected requests
      wr(2'd2, 32'hABCD_005A);
      rd(2'd2, 32'h5A, "b2b_en");
      rd(2'd1, 32'h0, "edge_reg");
      cs_ = 1'b1; as_ = 1'b0; rw = 1'b1;
      tick();
      cs_ = 1'b0; as_ = 1'b1; rw = 1'b1;
      tick();
      src = 8'h21;
      idle(2);
      rd(2'd3, 32'h21, "raw_s2");
      src = 8'h00;
      idle(3);
      // reset in the middle of a read
      wr(2'd2, 32'hFF);
      wr(2'd3, 32'hFF);
      tick();
      chk("pre_rst_irq", {24'd0, irq}, 32'hFF);
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd0;
      @(posedge clk);
      cyc++;
      #1 reset_ = 1'b0;
      cs_ = 1'b1; as_ = 1'b1;
      #1;
      chk("midrst_irq", {24'd0, irq}, 32'd0);
      chk("midrst_rdy", {31'd0, rdy_}, 32'd1);
      chk("midrst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;
      idle(1);
      rd(2'd0, 32'h0, "post_rst_pend");
      rd(2'd1, 32'h0, "post_rst_edge");
      rd(2'd2, 32'h0, "post_rst_en");
      chk("post_rst_irq", {24'd0, irq}, 32'd0);
      chk("sb_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
